// File: rtl/suu_pkg.sv
// Shared types for the MEM/WB pipeline register: width defaults, state encoding, entry bundle.
package suu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef enum logic [1:0] {
      MW_EMPTY = 2'd0,
      MW_ONE   = 2'd1,
      MW_FULL  = 2'd2
   } mw_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              wd;
   } mw_entry_t;

endpackage

// File: rtl/men_wb_if.sv
// MEM/WB handshake bundle: upstream result triple with valid/ready, downstream head with valid/ready.
interface men_wb_if #(
   parameter int unsigned DATA_W = suu_pkg::DATA_W,
   parameter int unsigned ADDR_W = suu_pkg::ADDR_W
) ();

   logic [DATA_W-1:0] i_w_reg_data;
   logic [ADDR_W-1:0] i_w_reg_addr;
   logic              i_wd;
   logic              i_valid;
   logic              o_ready;
   logic              wb_ready;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_w_reg_data;
   logic [ADDR_W-1:0] wb_w_reg_addr;
   logic              wb_wd;

   modport master (
      output i_w_reg_data, i_w_reg_addr, i_wd, i_valid, wb_ready,
      input  o_ready, wb_valid, wb_w_reg_data, wb_w_reg_addr, wb_wd
   );

   modport slave (
      input  i_w_reg_data, i_w_reg_addr, i_wd, i_valid, wb_ready,
      output o_ready, wb_valid, wb_w_reg_data, wb_w_reg_addr, wb_wd
   );

endinterface

// File: rtl/men_wb_slot.sv
// One MEM/WB entry register: async active-low clear, load enable, r0 write-enable masking on load.
module men_wb_slot #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] d_data,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_wd,
   output logic [DATA_W-1:0] q_data,
   output logic [ADDR_W-1:0] q_addr,
   output logic              q_wd
);

   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wd_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         addr_q <= '0;
         wd_q   <= 1'b0;
      end else if (load) begin
         data_q <= d_data;
         addr_q <= d_addr;
         // r0 is hardwired to zero, so never carry a write to it
         wd_q   <= d_wd & (d_addr != '0);
      end
   end

   assign q_data = data_q;
   assign q_addr = addr_q;
   assign q_wd   = wd_q;

endmodule

// File: rtl/men_wb.sv
// MEM/WB elastic register with a 2-entry skid buffer, synchronous flush and retire counter.
// Optional MEN_WB_FWD_EN adds a combinational forward of the youngest held entry.
module men_wb #(
   parameter int unsigned DATA_W = suu_pkg::DATA_W,
   parameter int unsigned ADDR_W = suu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   men_wb_if.slave           bus,
   output logic [31:0]       retire_cnt
`ifdef MEN_WB_FWD_EN
   ,
   output logic              fwd_wd,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   import suu_pkg::*;

   mw_state_e state_q, state_d;

   logic              in_fire, out_fire;
   logic              main_load, main_from_skid, skid_load;
   logic [DATA_W-1:0] main_d_data, main_data, skid_data;
   logic [ADDR_W-1:0] main_d_addr, main_addr, skid_addr;
   logic              main_d_wd, main_wd, skid_wd;
   logic [31:0]       cnt_q;

   // Ready depends on state only, so wb_ready never reaches o_ready combinationally
   assign bus.o_ready  = (state_q != MW_FULL);
   assign bus.wb_valid = (state_q != MW_EMPTY);
   assign in_fire      = bus.i_valid & bus.o_ready;
   assign out_fire     = bus.wb_valid & bus.wb_ready;

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         // Incoming entry dropped; a concurrent retire still completes via out_fire
         state_d = MW_EMPTY;
      end else begin
         case (state_q)
            MW_EMPTY: begin
               if (in_fire) begin
                  state_d   = MW_ONE;
                  main_load = 1'b1;
               end
            end
            MW_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_d   = MW_FULL;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_d = MW_EMPTY;
               end
            end
            MW_FULL: begin
               if (out_fire) begin
                  state_d        = MW_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = MW_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MW_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      main_d_data = bus.i_w_reg_data;
      main_d_addr = bus.i_w_reg_addr;
      main_d_wd   = bus.i_wd;
      if (main_from_skid) begin
         main_d_data = skid_data;
         main_d_addr = skid_addr;
         main_d_wd   = skid_wd;
      end
   end

   men_wb_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (main_load),
      .d_data (main_d_data),
      .d_addr (main_d_addr),
      .d_wd   (main_d_wd),
      .q_data (main_data),
      .q_addr (main_addr),
      .q_wd   (main_wd)
   );

   men_wb_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .d_data (bus.i_w_reg_data),
      .d_addr (bus.i_w_reg_addr),
      .d_wd   (bus.i_wd),
      .q_data (skid_data),
      .q_addr (skid_addr),
      .q_wd   (skid_wd)
   );

   assign bus.wb_w_reg_data = main_data;
   assign bus.wb_w_reg_addr = main_addr;
   assign bus.wb_wd         = main_wd & bus.wb_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (out_fire) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign retire_cnt = cnt_q;

`ifdef MEN_WB_FWD_EN
   always_comb begin
      fwd_data = main_data;
      fwd_addr = main_addr;
      fwd_wd   = main_wd & bus.wb_valid & ~flush;
      if (state_q == MW_FULL) begin
         fwd_data = skid_data;
         fwd_addr = skid_addr;
         fwd_wd   = skid_wd & ~flush;
      end
   end
`endif

endmodule

// File: tb/tb_men_wb.sv
// Self-checking bench for men_wb: scenario tasks plus a FIFO scoreboard on retired entries.
module tb_men_wb;
   import suu_pkg::*;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] retire_cnt;
`ifdef MEN_WB_FWD_EN
   logic        fwd_wd;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
`endif

   men_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   men_wb #(
      .DATA_W (32),
      .ADDR_W (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .bus        (bus.slave),
      .retire_cnt (retire_cnt)
`ifdef MEN_WB_FWD_EN
      ,
      .fwd_wd     (fwd_wd),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   int          n_out  = 0;
   logic [31:0] exp_retire = 0;
   mw_entry_t   sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: sampled at negedge, i.e. the handshake state just before the next posedge
   always @(negedge clk) begin
      mw_entry_t e;
      if (rst) begin
         if (bus.wb_valid && bus.wb_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: got data=%h with no expected entry", bus.wb_w_reg_data);
            end else begin
               e = sb.pop_front();
               if ({bus.wb_w_reg_data, bus.wb_w_reg_addr, bus.wb_wd} !== {e.data, e.addr, e.wd}) begin
                  errors++;
                  $display("FAIL sb_order: got %h/%0d/%b expected %h/%0d/%b",
                           bus.wb_w_reg_data, bus.wb_w_reg_addr, bus.wb_wd, e.data, e.addr, e.wd);
               end
            end
            exp_retire++;
            n_out++;
         end
         if (flush) begin
            sb.delete();
         end else if (bus.i_valid && bus.o_ready) begin
            e.data = bus.i_w_reg_data;
            e.addr = bus.i_w_reg_addr;
            e.wd   = bus.i_wd & (bus.i_w_reg_addr != 5'd0);
            sb.push_back(e);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] a, input logic w);
      bus.i_valid      = 1'b1;
      bus.i_w_reg_data = d;
      bus.i_w_reg_addr = a;
      bus.i_wd         = w;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({bus.o_ready, bus.wb_valid, bus.wb_wd, bus.wb_w_reg_data, bus.wb_w_reg_addr, retire_cnt}
          !== {1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_vals: rdy=%b v=%b wd=%b d=%h a=%0d cnt=%0d required 1 0 0 0 0 0",
                  bus.o_ready, bus.wb_valid, bus.wb_wd, bus.wb_w_reg_data, bus.wb_w_reg_addr,
                  retire_cnt);
      end
      #9 rst = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      bus.wb_ready = 1'b1;
      send(32'h1234_5678, 5'd3, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      checks++;
      if ({bus.wb_valid, bus.wb_w_reg_data, bus.wb_w_reg_addr, bus.wb_wd}
          !== {1'b1, 32'h1234_5678, 5'd3, 1'b1}) begin
         errors++;
         $display("FAIL single_out: v=%b d=%h a=%0d wd=%b required 1 12345678 3 1",
                  bus.wb_valid, bus.wb_w_reg_data, bus.wb_w_reg_addr, bus.wb_wd);
      end
      cyc();
      checks++;
      if ({bus.wb_valid, bus.wb_wd, retire_cnt} !== {1'b0, 1'b0, 32'd1}) begin
         errors++;
         $display("FAIL single_empty: v=%b wd=%b cnt=%0d required 0 0 1",
                  bus.wb_valid, bus.wb_wd, retire_cnt);
      end
   endtask

   task automatic test_backpressure();
      bus.wb_ready = 1'b0;
      send(32'hA, 5'd1, 1'b1);
      cyc();
      checks++;
      if (bus.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_one: o_ready=%b required 1", bus.o_ready);
      end
`ifdef MEN_WB_FWD_EN
      checks++;
      if ({fwd_wd, fwd_addr, fwd_data} !== {1'b1, 5'd1, 32'hA}) begin
         errors++;
         $display("FAIL fwd_one: %b/%0d/%h required 1/1/a", fwd_wd, fwd_addr, fwd_data);
      end
`endif
      send(32'hB, 5'd2, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      checks++;
      if ({bus.o_ready, bus.wb_valid, bus.wb_w_reg_data} !== {1'b0, 1'b1, 32'hA}) begin
         errors++;
         $display("FAIL bp_full: rdy=%b v=%b d=%h required 0 1 a",
                  bus.o_ready, bus.wb_valid, bus.wb_w_reg_data);
      end
`ifdef MEN_WB_FWD_EN
      checks++;
      if ({fwd_wd, fwd_addr, fwd_data} !== {1'b1, 5'd2, 32'hB}) begin
         errors++;
         $display("FAIL fwd_full: %b/%0d/%h required 1/2/b", fwd_wd, fwd_addr, fwd_data);
      end
`endif
      cyc();
      checks++;
      if (bus.o_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold: o_ready=%b required 0", bus.o_ready);
      end
      bus.wb_ready = 1'b1;
      cyc();
      checks++;
      if ({bus.o_ready, bus.wb_valid, bus.wb_w_reg_data} !== {1'b1, 1'b1, 32'hB}) begin
         errors++;
         $display("FAIL bp_release: rdy=%b v=%b d=%h required 1 1 b",
                  bus.o_ready, bus.wb_valid, bus.wb_w_reg_data);
      end
      cyc();
      checks++;
      if (bus.wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: wb_valid=%b required 0", bus.wb_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base_cnt;
      int          base_out;
      int          bubbles;
      base_cnt = retire_cnt;
      base_out = n_out;
      bubbles  = 0;
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         send(32'h100 + i, 5'((i % 31) + 1), i[0]);
         cyc();
         if (!bus.wb_valid) bubbles++;
      end
      bus.i_valid = 1'b0;
      cyc();
      checks++;
      if (bubbles != 0) begin
         errors++;
         $display("FAIL stream_bubbles: got %0d bubbles required 0", bubbles);
      end
      checks++;
      if ((retire_cnt - base_cnt) !== 32'd100 || (n_out - base_out) != 100) begin
         errors++;
         $display("FAIL stream_count: cnt_delta=%0d outs=%0d required 100",
                  retire_cnt - base_cnt, n_out - base_out);
      end
   endtask

   task automatic test_r0_mask();
      bus.wb_ready = 1'b0;
      send(32'hDEAD_BEEF, 5'd0, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      checks++;
      if ({bus.wb_valid, bus.wb_wd, bus.wb_w_reg_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL r0_mask: v=%b wd=%b d=%h required 1 0 deadbeef",
                  bus.wb_valid, bus.wb_wd, bus.wb_w_reg_data);
      end
      bus.wb_ready = 1'b1;
      cyc();
   endtask

   task automatic test_flush();
      logic [31:0] base_cnt;
      bus.wb_ready = 1'b0;
      send(32'hC, 5'd4, 1'b1);
      cyc();
      send(32'hD, 5'd5, 1'b1);
      cyc();
      checks++;
      if (bus.o_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_setup: o_ready=%b required 0", bus.o_ready);
      end
      base_cnt     = retire_cnt;
      flush        = 1'b1;
      bus.wb_ready = 1'b1;
      send(32'hE, 5'd6, 1'b1);
`ifdef MEN_WB_FWD_EN
      #1;
      checks++;
      if (fwd_wd !== 1'b0) begin
         errors++;
         $display("FAIL fwd_flush: fwd_wd=%b required 0", fwd_wd);
      end
`endif
      cyc();
      flush       = 1'b0;
      bus.i_valid = 1'b0;
      checks++;
      if ({bus.wb_valid, bus.wb_wd, bus.o_ready, bus.wb_w_reg_data} !== {1'b0, 1'b0, 1'b1, 32'hC}) begin
         errors++;
         $display("FAIL flush_empty: v=%b wd=%b rdy=%b d=%h required 0 0 1 c",
                  bus.wb_valid, bus.wb_wd, bus.o_ready, bus.wb_w_reg_data);
      end
      checks++;
      if (retire_cnt !== base_cnt + 32'd1 || retire_cnt !== exp_retire) begin
         errors++;
         $display("FAIL flush_retire: cnt=%0d required %0d", retire_cnt, base_cnt + 32'd1);
      end
      cyc();
      checks++;
      if (bus.wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_stays_empty: wb_valid=%b required 0", bus.wb_valid);
      end
   endtask

   task automatic test_async_reset();
      bus.wb_ready = 1'b0;
      send(32'h11, 5'd7, 1'b1);
      cyc();
      send(32'h22, 5'd8, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.o_ready, bus.wb_valid, bus.wb_wd, bus.wb_w_reg_data, bus.wb_w_reg_addr, retire_cnt}
          !== {1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 32'h0}) begin
         errors++;
         $display("FAIL async_reset: rdy=%b v=%b wd=%b d=%h a=%0d cnt=%0d required 1 0 0 0 0 0",
                  bus.o_ready, bus.wb_valid, bus.wb_wd, bus.wb_w_reg_data, bus.wb_w_reg_addr,
                  retire_cnt);
      end
      sb.delete();
      exp_retire = 0;
      #4 rst = 1'b1;
      bus.wb_ready = 1'b1;
      cyc();
      checks++;
      if ({bus.wb_valid, retire_cnt} !== {1'b0, 32'd0}) begin
         errors++;
         $display("FAIL async_after: v=%b cnt=%0d required 0 0", bus.wb_valid, retire_cnt);
      end
   endtask

   initial begin
      rst              = 1'b0;
      flush            = 1'b0;
      bus.i_valid      = 1'b0;
      bus.i_w_reg_data = '0;
      bus.i_w_reg_addr = '0;
      bus.i_wd         = 1'b0;
      bus.wb_ready     = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_r0_mask();
      test_flush();
      test_async_reset();
      send(32'h5A5A_0001, 5'd9, 1'b1);
      cyc();
      bus.i_valid = 1'b0;
      cyc();
      cyc();
      checks++;
      if (sb.size() != 0 || retire_cnt !== exp_retire) begin
         errors++;
         $display("FAIL final_drain: pending=%0d cnt=%0d required 0 %0d",
                  sb.size(), retire_cnt, exp_retire);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
